// File: rtl/issue_cmd_fifo.sv
// issue_cmd_fifo: DRAM command FIFO that enforces tCCD spacing between column pops
// Ports: clk, power_on_rst_n (async, active-low); push_valid/push_cmd/push_ready for enqueue;
//        cmd_valid/cmd/cmd_ready toward the bus driver; fifo_count, full, empty for status.
package issue_cmd_pkg;
    typedef enum logic [3:0] {
        ATCMD_NOP       = 4'd0,
        ATCMD_ACTIVE    = 4'd1,
        ATCMD_PRECHARGE = 4'd2,
        ATCMD_PREA      = 4'd3,
        ATCMD_READ      = 4'd4,
        ATCMD_WRITE     = 4'd5,
        ATCMD_RDA       = 4'd6,
        ATCMD_WRA       = 4'd7,
        ATCMD_REFRESH   = 4'd8,
        ATCMD_ZQCS      = 4'd9
    } sch_cmd_t;
    typedef struct packed {
        sch_cmd_t    cmd;
        logic [15:0] row;
        logic [9:0]  col;
        logic [2:0]  bank;
    } issue_fifo_cmd_in_t;
endpackage

module issue_cmd_fifo
    import issue_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TCCD  = 4
) (
    input  logic                     clk,
    input  logic                     power_on_rst_n,
    input  logic                     push_valid,
    input  issue_fifo_cmd_in_t       push_cmd,
    output logic                     push_ready,
    output logic                     cmd_valid,
    output issue_fifo_cmd_in_t       cmd,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TCCD) + 1;
    issue_fifo_cmd_in_t mem [DEPTH];
    issue_fifo_cmd_in_t head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ccd_cnt;
    logic head_col, push_fire, pop_fire;
    always_comb begin
        head       = mem[rd_ptr];
        head_col   = head.cmd inside {ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA};
        full       = fifo_count == (AW+1)'(DEPTH);
        empty      = fifo_count == '0;
        push_ready = !full;
        // Only column heads wait on the spacing counter; others bypass it.
        cmd_valid  = !empty && !(head_col && ccd_cnt != '0);
        cmd        = cmd_valid ? head : '0;
        push_fire  = push_valid && push_ready;
        pop_fire   = cmd_valid && cmd_ready;
    end
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_cmd;
    end
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ccd_cnt    <= '0;
        end else begin
            wr_ptr     <= push_fire ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop_fire ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count <= (push_fire && !pop_fire) ? fifo_count + (AW+1)'(1) :
                          (!push_fire && pop_fire) ? fifo_count - (AW+1)'(1) : fifo_count;
            ccd_cnt    <= (pop_fire && head_col) ? CW'(TCCD - 1) :
                          (ccd_cnt != '0) ? ccd_cnt - CW'(1) : ccd_cnt;
        end
    end
endmodule
